// File: rtl/rename_map_pkg.sv
// rename_map_pkg
// Shared sizing, typedefs and helpers for the two-wide rename stage.
//   areg_t / preg_t / tag_t : architectural reg, physical reg, branch tag
//   renamed_uop_t           : one slot of the rename output register
//   tag_valid / tag_to_idx  : branch tag range check and checkpoint index
package rename_map_pkg;

  localparam int NUM_AREGS              = 16;
  localparam int NUM_PREGS              = 64;
  localparam int MAX_PREDICT_DEPTH      = 4;
  localparam int MAX_PREDICT_DEPTH_BITS = 3;

  localparam int AREG_BITS     = $clog2(NUM_AREGS);
  localparam int PREG_BITS     = $clog2(NUM_PREGS);
  localparam int CKPT_IDX_BITS = $clog2(MAX_PREDICT_DEPTH);

  typedef logic [AREG_BITS-1:0]              areg_t;
  typedef logic [PREG_BITS-1:0]              preg_t;
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_t;
  typedef logic [CKPT_IDX_BITS-1:0]          ckpt_idx_t;

  localparam tag_t MAX_TAG = tag_t'(MAX_PREDICT_DEPTH);

  typedef struct packed {
    logic  valid;
    preg_t psrc1;
    preg_t psrc2;
    preg_t pdst;
    preg_t old_pdst;
    logic  has_dest;
    tag_t  spec_tag;
  } renamed_uop_t;

  // Tag 0 means "no branch"; tags above the checkpoint count have no storage.
  function automatic logic tag_valid(input tag_t t);
    return (t != '0) && (t <= MAX_TAG);
  endfunction

  // Tags are 1-based, checkpoint storage is 0-based.
  function automatic ckpt_idx_t tag_to_idx(input tag_t t);
    tag_t m1;
    m1 = t - tag_t'(1);
    return ckpt_idx_t'(m1);
  endfunction

endpackage

// File: rtl/rename_map_rat_checkpoints.sv
// rat_checkpoints
// Register alias table plus one full RAT snapshot per branch tag.
//   clk, reset              : clock, synchronous active-high reset
//   rd_areg / rd_preg       : six combinational RAT read ports
//   wr_en/wr_areg/wr_preg   : per-slot RAT writes, slot 1 applied after slot 0
//   snap_en / snap_tag      : per-slot checkpoint capture
//   restore_en/restore_tag  : copy a checkpoint back into the RAT
module rat_checkpoints
  import rename_map_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [5:0][AREG_BITS-1:0]         rd_areg,
  output logic [5:0][PREG_BITS-1:0]         rd_preg,
  input  logic [1:0]                        wr_en,
  input  logic [1:0][AREG_BITS-1:0]         wr_areg,
  input  logic [1:0][PREG_BITS-1:0]         wr_preg,
  input  logic [1:0]                        snap_en,
  input  logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] snap_tag,
  input  logic                              restore_en,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] restore_tag
);

  preg_t rat_q     [NUM_AREGS];
  preg_t ckpt_q    [MAX_PREDICT_DEPTH][NUM_AREGS];
  preg_t rat_slot0 [NUM_AREGS];
  preg_t rat_slot1 [NUM_AREGS];

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      rd_preg[i] = rat_q[rd_areg[i]];
    end
  end

  // Table as seen after slot 0's write and after both writes. A slot 0
  // branch snapshots the first view, a slot 1 branch the second, and the
  // second view is also the next RAT so slot 1 wins a WAW.
  always_comb begin
    for (int i = 0; i < NUM_AREGS; i++) begin
      rat_slot0[i] = (wr_en[0] && wr_areg[0] == areg_t'(i)) ? wr_preg[0] : rat_q[i];
    end
    for (int i = 0; i < NUM_AREGS; i++) begin
      rat_slot1[i] = (wr_en[1] && wr_areg[1] == areg_t'(i)) ? wr_preg[1] : rat_slot0[i];
    end
  end

  // The freelist holds back pregs 0..NUM_AREGS-1 at reset, so the identity
  // mapping is the consistent starting point for the RAT and every snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        rat_q[i] <= preg_t'(i);
      end
      for (int c = 0; c < MAX_PREDICT_DEPTH; c++) begin
        for (int i = 0; i < NUM_AREGS; i++) begin
          ckpt_q[c][i] <= preg_t'(i);
        end
      end
    end else begin
      if (restore_en) begin
        if (tag_valid(restore_tag)) begin
          rat_q <= ckpt_q[tag_to_idx(restore_tag)];
        end
      end else begin
        rat_q <= rat_slot1;
      end
      if (snap_en[0] && tag_valid(snap_tag[0])) begin
        ckpt_q[tag_to_idx(snap_tag[0])] <= rat_slot0;
      end
      if (snap_en[1] && tag_valid(snap_tag[1])) begin
        ckpt_q[tag_to_idx(snap_tag[1])] <= rat_slot1;
      end
    end
  end

endmodule

// File: rtl/rename_map.sv
// rename_map
// Two-wide rename stage between the freelist and dispatch/ROB.
//   clk, reset                       : clock, synchronous active-high reset
//   in_*                             : decode group (slot 0 older), in_valid/in_ready
//   fl_preg1/2, fl_num_free          : freelist candidates and count
//   fl_num_pull, fl_branch_tag_1/2   : allocation request back to the freelist
//   branch_shootdown, *_branch_tag   : mispredict restore
//   out_*                            : one-entry renamed output register, out_ready
module rename_map
  import rename_map_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [1:0]                             in_slot_valid,
  input  logic [1:0]                             in_has_dest,
  input  logic [1:0][AREG_BITS-1:0]              in_dst,
  input  logic [1:0][AREG_BITS-1:0]              in_src1,
  input  logic [1:0][AREG_BITS-1:0]              in_src2,
  input  logic [1:0]                             in_is_branch,
  input  logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] in_br_tag,
  input  logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] in_spec_tag,
  input  logic [PREG_BITS-1:0]                   fl_preg1,
  input  logic [PREG_BITS-1:0]                   fl_preg2,
  input  logic [PREG_BITS:0]                     fl_num_free,
  output logic [1:0]                             fl_num_pull,
  output logic [MAX_PREDICT_DEPTH_BITS-1:0]      fl_branch_tag_1,
  output logic [MAX_PREDICT_DEPTH_BITS-1:0]      fl_branch_tag_2,
  input  logic                                   branch_shootdown,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0]      shootdown_branch_tag,
  output logic [1:0]                             out_valid,
  input  logic                                   out_ready,
  output logic [1:0][PREG_BITS-1:0]              out_psrc1,
  output logic [1:0][PREG_BITS-1:0]              out_psrc2,
  output logic [1:0][PREG_BITS-1:0]              out_pdst,
  output logic [1:0][PREG_BITS-1:0]              out_old_pdst,
  output logic [1:0]                             out_has_dest,
  output logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] out_spec_tag
);

  logic [1:0]                wr;
  logic [1:0]                need;
  logic                      fire;
  logic                      out_valid_any;
  preg_t [1:0]               new_pdst;
  logic [5:0][AREG_BITS-1:0] rd_areg;
  logic [5:0][PREG_BITS-1:0] rd_preg;
  renamed_uop_t [1:0]        uop_d;
  renamed_uop_t [1:0]        out_q;

  // Handshake and freelist request. A write to areg 0 is discarded, so it
  // neither consumes a preg nor counts against fl_num_free.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr[k] = in_slot_valid[k] & in_has_dest[k] & (in_dst[k] != '0);
    end
    need          = {1'b0, wr[0]} + {1'b0, wr[1]};
    out_valid_any = out_q[0].valid | out_q[1].valid;
    in_ready      = !reset && !branch_shootdown && (!out_valid_any || out_ready) &&
                    (fl_num_free >= {{(PREG_BITS-1){1'b0}}, need});
    fire          = in_valid && in_ready;
    fl_num_pull   = fire ? need : 2'd0;
    new_pdst[0]   = fl_preg1;
    new_pdst[1]   = wr[0] ? fl_preg2 : fl_preg1;
    fl_branch_tag_1 = wr[0] ? in_spec_tag[0] : (wr[1] ? in_spec_tag[1] : '0);
    fl_branch_tag_2 = (wr[0] && wr[1]) ? in_spec_tag[1] : '0;
  end

  always_comb begin
    rd_areg[0] = in_src1[0];
    rd_areg[1] = in_src2[0];
    rd_areg[2] = in_src1[1];
    rd_areg[3] = in_src2[1];
    rd_areg[4] = in_dst[0];
    rd_areg[5] = in_dst[1];
  end

  // Slot 1 cannot see slot 0's RAT write until next cycle, so any slot 1
  // source or dest naming slot 0's dest is bypassed to slot 0's new preg.
  always_comb begin
    uop_d = '0;
    for (int k = 0; k < 2; k++) begin
      uop_d[k].valid    = in_slot_valid[k];
      uop_d[k].pdst     = wr[k] ? new_pdst[k] : '0;
      uop_d[k].has_dest = in_has_dest[k];
      uop_d[k].spec_tag = in_spec_tag[k];
    end
    uop_d[0].psrc1    = (in_src1[0] == '0) ? '0 : rd_preg[0];
    uop_d[0].psrc2    = (in_src2[0] == '0) ? '0 : rd_preg[1];
    uop_d[0].old_pdst = rd_preg[4];
    uop_d[1].psrc1    = (in_src1[1] == '0) ? '0 :
                        (wr[0] && in_src1[1] == in_dst[0]) ? new_pdst[0] : rd_preg[2];
    uop_d[1].psrc2    = (in_src2[1] == '0) ? '0 :
                        (wr[0] && in_src2[1] == in_dst[0]) ? new_pdst[0] : rd_preg[3];
    uop_d[1].old_pdst = (wr[0] && in_dst[1] == in_dst[0]) ? new_pdst[0] : rd_preg[5];
  end

  rat_checkpoints u_rat (
    .clk         (clk),
    .reset       (reset),
    .rd_areg     (rd_areg),
    .rd_preg     (rd_preg),
    .wr_en       (wr & {2{fire}}),
    .wr_areg     (in_dst),
    .wr_preg     (new_pdst),
    .snap_en     (in_is_branch & in_slot_valid & {2{fire}}),
    .snap_tag    (in_br_tag),
    .restore_en  (branch_shootdown),
    .restore_tag (shootdown_branch_tag)
  );

  // Output register. On shootdown, slots at or younger than the bad tag are
  // squashed; if dispatch takes the register that same cycle, everything
  // that survived has been consumed, so the register simply empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (branch_shootdown) begin
      for (int k = 0; k < 2; k++) begin
        if (out_ready || out_q[k].spec_tag >= shootdown_branch_tag) begin
          out_q[k].valid <= 1'b0;
        end
      end
    end else if (fire) begin
      out_q <= uop_d;
    end else if (out_ready) begin
      out_q[0].valid <= 1'b0;
      out_q[1].valid <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      out_valid[k]    = out_q[k].valid;
      out_psrc1[k]    = out_q[k].psrc1;
      out_psrc2[k]    = out_q[k].psrc2;
      out_pdst[k]     = out_q[k].pdst;
      out_old_pdst[k] = out_q[k].old_pdst;
      out_has_dest[k] = out_q[k].has_dest;
      out_spec_tag[k] = out_q[k].spec_tag;
    end
  end

  shootdown_tag_nonzero: assert property (@(posedge clk) disable iff (reset)
    branch_shootdown |-> shootdown_branch_tag != '0);

endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map
// Directed bench for rename_map: a sequential RAT/checkpoint model produces
// the expected renamed group on each accepted input; the group is queued
// and compared when the output register shows it.
module tb_rename_map;
  import rename_map_pkg::*;

  typedef logic [PREG_BITS:0] cnt_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_slot_valid, in_has_dest, in_is_branch;
  logic [1:0][AREG_BITS-1:0] in_dst, in_src1, in_src2;
  logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] in_br_tag, in_spec_tag;
  logic [PREG_BITS-1:0]      fl_preg1, fl_preg2;
  logic [PREG_BITS:0]        fl_num_free;
  logic [1:0]                fl_num_pull;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] fl_branch_tag_1, fl_branch_tag_2;
  logic                      branch_shootdown;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag;
  logic [1:0]                out_valid;
  logic                      out_ready;
  logic [1:0][PREG_BITS-1:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
  logic [1:0]                out_has_dest;
  logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] out_spec_tag;

  always #5 clk = ~clk;

  rename_map dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_has_dest(in_has_dest),
    .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
    .in_is_branch(in_is_branch), .in_br_tag(in_br_tag), .in_spec_tag(in_spec_tag),
    .fl_preg1(fl_preg1), .fl_preg2(fl_preg2), .fl_num_free(fl_num_free),
    .fl_num_pull(fl_num_pull), .fl_branch_tag_1(fl_branch_tag_1),
    .fl_branch_tag_2(fl_branch_tag_2), .branch_shootdown(branch_shootdown),
    .shootdown_branch_tag(shootdown_branch_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_psrc1(out_psrc1), .out_psrc2(out_psrc2),
    .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
    .out_has_dest(out_has_dest), .out_spec_tag(out_spec_tag)
  );

  typedef struct packed {
    logic  valid;
    logic  wr;
    preg_t psrc1;
    preg_t psrc2;
    preg_t pdst;
    preg_t old_pdst;
    logic  has_dest;
    tag_t  spec_tag;
  } exp_slot_t;
  typedef exp_slot_t [1:0] exp_group_t;

  typedef struct packed {
    logic [1:0] sv;
    logic [1:0] hd;
    logic [1:0] br;
    logic [1:0][AREG_BITS-1:0] dst;
    logic [1:0][AREG_BITS-1:0] s1;
    logic [1:0][AREG_BITS-1:0] s2;
    logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] btag;
    logic [1:0][MAX_PREDICT_DEPTH_BITS-1:0] stag;
  } group_t;

  exp_group_t exp_q[$];
  preg_t      model_rat  [NUM_AREGS];
  preg_t      model_ckpt [MAX_PREDICT_DEPTH][NUM_AREGS];
  int         tests    = 0;
  int         failures = 0;

  task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    for (int i = 0; i < NUM_AREGS; i++) begin
      model_rat[i] = preg_t'(i);
      for (int c = 0; c < MAX_PREDICT_DEPTH; c++) model_ckpt[c][i] = preg_t'(i);
    end
  endtask

  function automatic group_t setSlot(input group_t g, input bit k, input logic hd, input int dst,
                                     input int s1, input int s2, input logic br, input int btag,
                                     input int stag);
    group_t r;
    r = g;
    r.sv[k]   = 1'b1;
    r.hd[k]   = hd;
    r.dst[k]  = areg_t'(dst);
    r.s1[k]   = areg_t'(s1);
    r.s2[k]   = areg_t'(s2);
    r.br[k]   = br;
    r.btag[k] = tag_t'(btag);
    r.stag[k] = tag_t'(stag);
    return r;
  endfunction

  // Compare the output register with the oldest queued expectation.
  task automatic checkOutput();
    exp_group_t e;
    if (exp_q.size() == 0) begin
      checkValue("out_valid_idle", 32'(out_valid), 32'd0);
    end else begin
      e = exp_q[0];
      checkValue("out_valid", 32'(out_valid), 32'({e[1].valid, e[0].valid}));
      for (int k = 0; k < 2; k++) begin
        if (e[k].valid) begin
          checkValue($sformatf("slot%0d.psrc1", k), 32'(out_psrc1[k]), 32'(e[k].psrc1));
          checkValue($sformatf("slot%0d.psrc2", k), 32'(out_psrc2[k]), 32'(e[k].psrc2));
          checkValue($sformatf("slot%0d.has_dest", k), 32'(out_has_dest[k]), 32'(e[k].has_dest));
          checkValue($sformatf("slot%0d.spec_tag", k), 32'(out_spec_tag[k]), 32'(e[k].spec_tag));
          if (e[k].wr) begin
            checkValue($sformatf("slot%0d.pdst", k), 32'(out_pdst[k]), 32'(e[k].pdst));
            checkValue($sformatf("slot%0d.old_pdst", k), 32'(out_old_pdst[k]), 32'(e[k].old_pdst));
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the negedge, check the combinational
  // handshake, update the model/scoreboard, then advance one cycle.
  task automatic applyStimulus(input group_t g, input logic valid, input int p1, input int p2,
                               input int nfree, input logic ordy, input logic shoot,
                               input int stag, input logic exp_ready);
    exp_group_t e;
    logic [1:0] w;
    logic [1:0] need;
    logic       fire;
    preg_t      np [2];
    preg_t      tmp [NUM_AREGS];
    in_valid = valid;
    in_slot_valid = g.sv; in_has_dest = g.hd; in_is_branch = g.br;
    in_dst = g.dst; in_src1 = g.s1; in_src2 = g.s2;
    in_br_tag = g.btag; in_spec_tag = g.stag;
    fl_preg1 = preg_t'(p1); fl_preg2 = preg_t'(p2); fl_num_free = cnt_t'(nfree);
    out_ready = ordy; branch_shootdown = shoot; shootdown_branch_tag = tag_t'(stag);
    #1;
    fire = valid & exp_ready;
    for (int k = 0; k < 2; k++) w[k] = g.sv[k] & g.hd[k] & (g.dst[k] != '0);
    need = fire ? (2'(w[0]) + 2'(w[1])) : 2'd0;
    checkValue("in_ready", 32'(in_ready), 32'(exp_ready));
    checkValue("fl_num_pull", 32'(fl_num_pull), 32'(need));
    if (shoot) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!ordy) begin
          for (int k = 0; k < 2; k++) if (e[k].spec_tag >= tag_t'(stag)) e[k].valid = 1'b0;
          if (e[0].valid || e[1].valid) exp_q.push_front(e);
        end
      end
      model_rat = model_ckpt[stag-1];
    end else begin
      if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fire) begin
        if (need != 2'd0)
          checkValue("fl_branch_tag_1", 32'(fl_branch_tag_1), 32'(w[0] ? g.stag[0] : g.stag[1]));
        if (w == 2'b11)
          checkValue("fl_branch_tag_2", 32'(fl_branch_tag_2), 32'(g.stag[1]));
        e = '0;
        tmp = model_rat;
        np[0] = preg_t'(p1);
        np[1] = w[0] ? preg_t'(p2) : preg_t'(p1);
        for (int k = 0; k < 2; k++) begin
          e[k].valid    = g.sv[k];
          e[k].wr       = w[k];
          e[k].has_dest = g.hd[k];
          e[k].spec_tag = g.stag[k];
          e[k].psrc1    = (g.s1[k] == '0) ? '0 : tmp[g.s1[k]];
          e[k].psrc2    = (g.s2[k] == '0) ? '0 : tmp[g.s2[k]];
          e[k].old_pdst = tmp[g.dst[k]];
          e[k].pdst     = np[k];
          if (w[k]) tmp[g.dst[k]] = np[k];
          if (g.sv[k] && g.br[k] && g.btag[k] != '0) model_ckpt[int'(g.btag[k]) - 1] = tmp;
        end
        model_rat = tmp;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic resetDut(input group_t g);
    reset = 1'b1;
    in_valid = 1'b1; in_slot_valid = g.sv; in_has_dest = g.hd; in_dst = g.dst;
    in_src1 = g.s1; in_src2 = g.s2; in_is_branch = g.br; in_br_tag = g.btag;
    in_spec_tag = g.stag; out_ready = 1'b1; branch_shootdown = 1'b0;
    fl_num_free = cnt_t'(10);
    #1;
    checkValue("reset.in_ready", 32'(in_ready), 32'd0);
    checkValue("reset.fl_num_pull", 32'(fl_num_pull), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    modelReset();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    group_t g;
    reset = 1'b1; in_valid = 1'b0; in_slot_valid = '0; in_has_dest = '0; in_dst = '0;
    in_src1 = '0; in_src2 = '0; in_is_branch = '0; in_br_tag = '0; in_spec_tag = '0;
    fl_preg1 = '0; fl_preg2 = '0; fl_num_free = '0; out_ready = 1'b0;
    branch_shootdown = 1'b0; shootdown_branch_tag = '0;
    modelReset();
    @(negedge clk);
    g = '0; g = setSlot(g, 0, 1, 3, 1, 2, 0, 0, 0);
    resetDut(g);
    checkOutput();

    // r3 <- r1 + r2
    applyStimulus(g, 1, 20, 21, 10, 1, 0, 0, 1);
    checkOutput();
    // r5 <- r1 ; r6 <- r5 (intra-group bypass)
    g = '0; g = setSlot(g, 0, 1, 5, 1, 0, 0, 0, 0); g = setSlot(g, 1, 1, 6, 5, 0, 0, 0, 0);
    applyStimulus(g, 1, 30, 31, 10, 1, 0, 0, 1);
    checkOutput();
    // WAW on r4
    g = '0; g = setSlot(g, 0, 1, 4, 3, 0, 0, 0, 0); g = setSlot(g, 1, 1, 4, 2, 0, 0, 0, 0);
    applyStimulus(g, 1, 40, 41, 10, 1, 0, 0, 1);
    checkOutput();
    // r10 <- r4 + r6 with exactly one free preg
    g = '0; g = setSlot(g, 0, 1, 10, 4, 6, 0, 0, 0);
    applyStimulus(g, 1, 42, 43, 1, 1, 0, 0, 1);
    checkOutput();
    // two dests, one free preg: stall, then accepted with two
    g = '0; g = setSlot(g, 0, 1, 11, 0, 0, 0, 0, 0); g = setSlot(g, 1, 1, 12, 11, 0, 0, 0, 0);
    applyStimulus(g, 1, 43, 44, 1, 1, 0, 0, 0);
    checkOutput();
    applyStimulus(g, 1, 43, 44, 2, 1, 0, 0, 1);
    checkOutput();
    // write to r0 is dropped; slot 1 takes preg1
    g = '0; g = setSlot(g, 0, 1, 0, 1, 0, 0, 0, 0); g = setSlot(g, 1, 1, 13, 2, 0, 0, 0, 0);
    applyStimulus(g, 1, 45, 46, 1, 1, 0, 0, 1);
    checkOutput();
    // slot 0 branch tag 1, slot 1 r7 <- r3 speculative
    g = '0; g = setSlot(g, 0, 0, 0, 1, 2, 1, 1, 0); g = setSlot(g, 1, 1, 7, 3, 0, 0, 0, 1);
    applyStimulus(g, 1, 50, 51, 5, 1, 0, 0, 1);
    checkOutput();
    // r8 <- r7 under tag 1
    g = '0; g = setSlot(g, 0, 1, 8, 7, 0, 0, 0, 1);
    applyStimulus(g, 1, 51, 52, 5, 1, 0, 0, 1);
    checkOutput();
    // shootdown tag 1 while stalled, with a competing group
    g = '0; g = setSlot(g, 0, 1, 14, 1, 0, 0, 0, 0);
    applyStimulus(g, 1, 60, 61, 10, 0, 1, 1, 0);
    checkOutput();
    // r1 <- r7 + r8 ; r2 <- r3 + r4 : r7/r8 restored
    g = '0; g = setSlot(g, 0, 1, 1, 7, 8, 0, 0, 0); g = setSlot(g, 1, 1, 2, 3, 4, 0, 0, 0);
    applyStimulus(g, 1, 52, 53, 10, 1, 0, 0, 1);
    checkOutput();
    // slot 0 branch tag 2, slot 1 r9 <- r1 under tag 2
    g = '0; g = setSlot(g, 0, 0, 0, 3, 0, 1, 2, 0); g = setSlot(g, 1, 1, 9, 1, 0, 0, 0, 2);
    applyStimulus(g, 1, 54, 55, 10, 1, 0, 0, 1);
    // output held for three cycles
    g = '0; g = setSlot(g, 0, 1, 14, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checkOutput();
      applyStimulus(g, 1, 60, 61, 10, 0, 0, 0, 0);
    end
    checkOutput();
    // shootdown tag 2: branch slot survives, slot 1 squashed, fire dropped
    applyStimulus(g, 1, 60, 61, 10, 0, 1, 2, 0);
    checkOutput();
    // r15 <- r9 + r7
    g = '0; g = setSlot(g, 0, 1, 15, 9, 7, 0, 0, 0);
    applyStimulus(g, 1, 55, 56, 10, 1, 0, 0, 1);
    checkOutput();
    // no-dest uop with an empty freelist
    g = '0; g = setSlot(g, 0, 0, 0, 1, 2, 0, 0, 0);
    applyStimulus(g, 1, 57, 58, 0, 1, 0, 0, 1);
    checkOutput();
    // reset with a live output
    g = '0; g = setSlot(g, 0, 1, 5, 3, 1, 0, 0, 0);
    resetDut(g);
    checkOutput();
    applyStimulus(g, 1, 60, 61, 10, 1, 0, 0, 1);
    checkOutput();
    g = '0;
    applyStimulus(g, 0, 0, 0, 10, 1, 0, 0, 1);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- Two-wide register rename stage, directly downstream of the physical-register freelist; it consumes `preg1`/`preg2`/`num_free` and drives the freelist allocation request.
- Holds the architectural-to-physical register alias table (RAT) and one RAT checkpoint per branch tag, and restores the RAT on `branch_shootdown`.
- Emits renamed uops through a one-entry output register to dispatch/ROB, including the previous physical destination that the ROB frees at commit.

Parameters:
- NUM_AREGS, 16, architectural registers; areg 0 is hardwired zero.
- NUM_PREGS, 64, physical registers; must match the freelist.
- MAX_PREDICT_DEPTH, 4, number of checkpoints; tag 0 means "none", tags 1..MAX_PREDICT_DEPTH are valid.
- MAX_PREDICT_DEPTH_BITS, 3, tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode group valid
- in_ready  out  1  group accepted this cycle when in_valid & in_ready
- in_slot_valid  in  2  per-slot uop present; slot 0 is older
- in_has_dest  in  2  slot writes a register
- in_dst / in_src1 / in_src2  in  2x$clog2(NUM_AREGS)  arch registers per slot
- in_is_branch  in  2  slot takes a checkpoint
- in_br_tag  in  2xMAX_PREDICT_DEPTH_BITS  checkpoint tag of a branch slot
- in_spec_tag  in  2xMAX_PREDICT_DEPTH_BITS  youngest unresolved older branch tag (0 = non-speculative)
- fl_preg1 / fl_preg2  in  $clog2(NUM_PREGS)  freelist candidates
- fl_num_free  in  $clog2(NUM_PREGS)+1  freelist count
- fl_num_pull  out  2  pregs consumed this cycle (0..2)
- fl_branch_tag_1 / fl_branch_tag_2  out  MAX_PREDICT_DEPTH_BITS  spec tag attached to preg1/preg2
- branch_shootdown  in  1  mispredict
- shootdown_branch_tag  in  MAX_PREDICT_DEPTH_BITS  mispredicted branch tag
- out_valid  out  2  renamed slot valid
- out_ready  in  1  dispatch accepts the output register
- out_psrc1 / out_psrc2 / out_pdst / out_old_pdst  out  2x$clog2(NUM_PREGS)  renamed operands
- out_has_dest, out_spec_tag  out  per slot  passed through

Behaviour:
- Reset:
  - RAT[i] = i for all i.
  - All checkpoints = identity.
  - out_valid = 0; in_ready = 0 during the reset cycle; fl_num_pull = 0.
  - Integration requirement: the freelist excludes pregs 0..NUM_AREGS-1 at reset.
- Effective dest: `wr[k] = in_slot_valid[k] & in_has_dest[k] & (in_dst[k] != 0)`. `need = wr[0] + wr[1]`.
- Accept condition: `in_ready = !reset & !branch_shootdown & (!out_valid_any | out_ready) & (fl_num_free >= need)`. Fire = in_valid & in_ready.
- Preg assignment on fire:
  - slot 0 takes fl_preg1 if wr[0].
  - slot 1 takes fl_preg1 if !wr[0], else fl_preg2.
  - fl_num_pull = need, driven combinationally only on fire; otherwise 0.
  - fl_branch_tag_1/2 carry the in_spec_tag of the slot owning preg1/preg2.
- Sources:
  - areg 0 reads preg 0.
  - slot 1 src equal to in_dst[0] with wr[0] bypasses to slot 0's new preg.
  - All other sources read the current RAT.
- old_pdst:
  - slot 0 = RAT[in_dst[0]].
  - slot 1 = slot 0's new preg if wr[0] and the dests match, else RAT[in_dst[1]].
- RAT update on fire: slot 0 is written first, then slot 1; on WAW, slot 1 wins.
- Checkpoint on fire when slot k is a branch with in_br_tag = t != 0: checkpoint[t-1] <= RAT state after slot k's update.
  - Slot 0 branch: includes slot 0 only, not slot 1.
  - Slot 1 branch: includes both slots.
- Latency: one cycle, input group to output register. The output register holds while out_valid_any & !out_ready.
- Shootdown with tag t (any cycle, including while stalled):
  - RAT <= checkpoint[t-1] next cycle; no input is accepted that cycle.
  - Output slots with out_spec_tag >= t have out_valid cleared; the branch itself (spec_tag < t) survives.
  - t = 0 is illegal (assertion).
- Shootdown wins over a same-cycle fire; the group is dropped and fl_num_pull = 0.
- Reset mid-operation discards all state and returns to reset values.

Decomposition:
- Shared package:
  - NUM_AREGS, NUM_PREGS, MAX_PREDICT_DEPTH, MAX_PREDICT_DEPTH_BITS.
  - `areg_t` and `preg_t` / `tag_t` typedefs.
  - `renamed_uop_t` struct {valid, psrc1, psrc2, pdst, old_pdst, has_dest, spec_tag}.
- One sub-module, `rat_checkpoints`: the RAT array plus checkpoint storage with write/snapshot/restore ports. The top level holds the handshake, bypass and output register.

Test Plan:
- Reset, then single slot `r3 <- r1 + r2`, fl_preg1 = 20 → psrc 1/2, pdst 20, old_pdst 3, fl_num_pull = 1, out_valid next cycle.
- Group `r5 <- r1`, `r6 <- r5` with preg1 = 30, preg2 = 31 → slot 1 psrc1 = 30, pdst 31, fl_num_pull = 2.
- WAW `r4 <- ...`, `r4 <- ...` with pregs 40/41 → slot 1 old_pdst = 40; a later read of r4 gives 41.
- fl_num_free = 1 with two dests → in_ready = 0, fl_num_pull = 0; raise to 2 → accepted.
- Slot 0 branch tag 1, slot 1 writes r7→50; next group writes r8→51 with spec_tag 1; shootdown tag 1 → RAT[7] = 7, RAT[8] = 8, younger output slots dropped.
- out_ready = 0 for 3 cycles → output held stable, in_ready = 0, no fl_num_pull.
